// File: rtl/floo_output_port_arbiter.sv
// Output-port arbiter for a NoC router: round-robin choice among input ports,
// held on one input from the first offered flit until its last flit is accepted.
module floo_output_port_arbiter #(
   parameter int unsigned NumInp   = 5,
   parameter type         flit_t   = logic [63:0],
   parameter int unsigned IdxWidth = $clog2(NumInp)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumInp-1:0]   valid_i,
   output logic [NumInp-1:0]   ready_o,
   input  flit_t               data_i [NumInp],
   input  logic [NumInp-1:0]   last_i,
   output logic                valid_o,
   input  logic                ready_i,
   output flit_t               data_o,
   output logic                last_o,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic                locked_o,
   output logic [15:0]         pkt_cnt_o
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t              state_reg;
   logic [IdxWidth-1:0] rr_ptr_reg;
   logic [IdxWidth-1:0] lock_idx_reg;
   logic [15:0]         pkt_cnt_reg;

   logic [IdxWidth-1:0] arb_idx;
   logic                arb_found;
   logic [IdxWidth-1:0] cand;
   logic [IdxWidth-1:0] sel;
   logic                grant_ready;
   logic                handshake;

   function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] idx);
      return (idx == IdxWidth'(NumInp - 1)) ? '0 : idx + IdxWidth'(1);
   endfunction

   // Cyclic priority search starting at rr_ptr; the first valid input met wins.
   always_comb begin
      arb_idx   = rr_ptr_reg;
      arb_found = 1'b0;
      cand      = rr_ptr_reg;
      for (int unsigned k = 0; k < NumInp; k++) begin
         if (!arb_found && valid_i[cand]) begin
            arb_idx   = cand;
            arb_found = 1'b1;
         end
         cand = wrap_inc(cand);
      end
   end

   assign sel       = (state_reg == LOCKED) ? lock_idx_reg : arb_idx;
   assign valid_o   = valid_i[sel];
   assign data_o    = data_i[sel];
   assign last_o    = last_i[sel];
   assign gnt_idx_o = sel;
   assign handshake = valid_o && ready_i;

   // While locked the owner sees ready_i even during a bubble; when idle only a real winner does.
   assign grant_ready = ready_i && ((state_reg == LOCKED) || arb_found);

   for (genvar gi = 0; gi < NumInp; gi++) begin : g_ready
      assign ready_o[gi] = grant_ready && (sel == IdxWidth'(gi));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         lock_idx_reg <= '0;
         pkt_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (handshake && last_o) begin
                  rr_ptr_reg  <= wrap_inc(sel);
                  pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
               end else if (valid_o) begin
                  // Either a multi-flit packet started or the flit is stalled:
                  // in both cases the grant must not move until the last flit goes.
                  state_reg    <= LOCKED;
                  lock_idx_reg <= sel;
               end
            end
            LOCKED: begin
               if (handshake && last_o) begin
                  state_reg   <= IDLE;
                  rr_ptr_reg  <= wrap_inc(lock_idx_reg);
                  pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign locked_o  = (state_reg == LOCKED);
   assign pkt_cnt_o = pkt_cnt_reg;

endmodule

// File: tb/tb_floo_output_port_arbiter.sv
// Directed bench for floo_output_port_arbiter with four inputs; expected values
// are worked out by hand for each step.
module tb_floo_output_port_arbiter;

   localparam int unsigned N = 4;

   logic          clk_i;
   logic          rst_ni;
   logic [N-1:0]  valid_i;
   logic [N-1:0]  ready_o;
   logic [63:0]   data_i [N];
   logic [N-1:0]  last_i;
   logic          valid_o;
   logic          ready_i;
   logic [63:0]   data_o;
   logic          last_o;
   logic [1:0]    gnt_idx_o;
   logic          locked_o;
   logic [15:0]   pkt_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   floo_output_port_arbiter #(
      .NumInp (N),
      .flit_t (logic [63:0])
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .data_i    (data_i),
      .last_i    (last_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .data_o    (data_o),
      .last_o    (last_o),
      .gnt_idx_o (gnt_idx_o),
      .locked_o  (locked_o),
      .pkt_cnt_o (pkt_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then changed 2 time units after the edge.
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int unsigned port, input int unsigned flit);
      data_i[port] = 64'h1000 * port + 64'(flit);
   endtask

   initial begin
      rst_ni  = 1'b0;
      valid_i = '0;
      last_i  = '0;
      ready_i = 1'b0;
      for (int i = 0; i < int'(N); i++) set_data(i, 0);

      // Reset state
      tick();
      tick();
      settle();
      check("rst_valid_o", 64'(valid_o), 64'd0);
      check("rst_ready_o", 64'(ready_o), 64'd0);
      check("rst_gnt", 64'(gnt_idx_o), 64'd0);
      check("rst_locked", 64'(locked_o), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
      tick();
      rst_ni = 1'b1;
      tick();

      // Round robin over four single-flit requesters
      valid_i = 4'b1111;
      last_i  = 4'b1111;
      ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         settle();
         check("rr_gnt", 64'(gnt_idx_o), 64'(c % 4));
         check("rr_ready", 64'(ready_o), 64'(1 << (c % 4)));
         $display("rr cycle %0d: gnt=%0d", c, gnt_idx_o);
         tick();
      end
      valid_i = '0;
      settle();
      check("rr_pkt_cnt", 64'(pkt_cnt_o), 64'd8);

      // Three-flit packet from input 1 while input 2 waits
      valid_i = 4'b0110;
      last_i  = 4'b0100;
      set_data(1, 0);
      set_data(2, 7);
      settle();
      check("pk_f0_gnt", 64'(gnt_idx_o), 64'd1);
      check("pk_f0_data", data_o, 64'h1000);
      check("pk_f0_locked", 64'(locked_o), 64'd0);
      check("pk_f0_ready", 64'(ready_o), 64'b0010);
      tick();
      set_data(1, 1);
      settle();
      check("pk_f1_data", data_o, 64'h1001);
      check("pk_f1_locked", 64'(locked_o), 64'd1);
      check("pk_f1_ready", 64'(ready_o), 64'b0010);
      tick();
      set_data(1, 2);
      last_i = 4'b0110;
      settle();
      check("pk_f2_data", data_o, 64'h1002);
      check("pk_f2_last", 64'(last_o), 64'd1);
      check("pk_f2_locked", 64'(locked_o), 64'd1);
      check("pk_f2_ready", 64'(ready_o), 64'b0010);
      tick();
      settle();
      check("pk_next_gnt", 64'(gnt_idx_o), 64'd2);
      check("pk_next_data", data_o, 64'h2007);
      check("pk_next_locked", 64'(locked_o), 64'd0);
      check("pk_next_ready", 64'(ready_o), 64'b0100);
      tick();
      valid_i = '0;
      settle();
      check("pk_pkt_cnt", 64'(pkt_cnt_o), 64'd10);

      // Stalled single flit from input 3 keeps the grant (rr_ptr is 3 here)
      valid_i = 4'b1000;
      last_i  = 4'b1001;
      ready_i = 1'b0;
      settle();
      check("st_gnt0", 64'(gnt_idx_o), 64'd3);
      check("st_valid0", 64'(valid_o), 64'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         settle();
         check("st_gnt", 64'(gnt_idx_o), 64'd3);
         check("st_locked", 64'(locked_o), 64'd1);
      end
      tick();
      valid_i = 4'b1001;
      settle();
      check("st_gnt_in0", 64'(gnt_idx_o), 64'd3);
      check("st_ready_in0", 64'(ready_o), 64'b0000);
      ready_i = 1'b1;
      settle();
      check("st_hs_gnt", 64'(gnt_idx_o), 64'd3);
      check("st_hs_ready", 64'(ready_o), 64'b1000);
      tick();
      valid_i = 4'b0001;
      settle();
      check("st_after_gnt", 64'(gnt_idx_o), 64'd0);
      check("st_after_locked", 64'(locked_o), 64'd0);
      check("st_after_cnt", 64'(pkt_cnt_o), 64'd11);
      tick();
      valid_i = '0;
      settle();
      check("st_pkt_cnt", 64'(pkt_cnt_o), 64'd12);

      // Bubble in a packet from input 2 while input 0 is valid (rr_ptr is 1)
      valid_i = 4'b0101;
      last_i  = 4'b0001;
      set_data(2, 0);
      settle();
      check("bb_f0_gnt", 64'(gnt_idx_o), 64'd2);
      check("bb_f0_data", data_o, 64'h2000);
      tick();
      valid_i = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         settle();
         check("bb_valid_o", 64'(valid_o), 64'd0);
         check("bb_gnt", 64'(gnt_idx_o), 64'd2);
         check("bb_ready", 64'(ready_o), 64'b0100);
         tick();
      end
      valid_i = 4'b0101;
      last_i  = 4'b0101;
      set_data(2, 1);
      settle();
      check("bb_f1_gnt", 64'(gnt_idx_o), 64'd2);
      check("bb_f1_data", data_o, 64'h2001);
      check("bb_f1_last", 64'(last_o), 64'd1);
      tick();
      valid_i = 4'b0001;
      settle();
      check("bb_in0_gnt", 64'(gnt_idx_o), 64'd0);
      check("bb_in0_cnt", 64'(pkt_cnt_o), 64'd13);
      tick();
      valid_i = '0;
      settle();
      check("bb_pkt_cnt", 64'(pkt_cnt_o), 64'd14);

      // Reset while locked on input 3 (rr_ptr is 1)
      valid_i = 4'b1000;
      last_i  = 4'b0000;
      settle();
      check("rl_gnt", 64'(gnt_idx_o), 64'd3);
      tick();
      settle();
      check("rl_locked", 64'(locked_o), 64'd1);
      rst_ni = 1'b0;
      settle();
      check("rl_locked_rst", 64'(locked_o), 64'd0);
      check("rl_cnt_rst", 64'(pkt_cnt_o), 64'd0);
      tick();
      rst_ni  = 1'b1;
      valid_i = 4'b1010;
      last_i  = 4'b1010;
      settle();
      check("rl_next_gnt", 64'(gnt_idx_o), 64'd1);
      check("rl_next_ready", 64'(ready_o), 64'b0010);
      tick();

      // Packet counter wrap: one packet so far, 65534 more reach FFFF
      valid_i = 4'b0001;
      last_i  = 4'b0001;
      settle();
      check("wr_start_cnt", 64'(pkt_cnt_o), 64'd1);
      for (int c = 0; c < 65534; c++) tick();
      settle();
      check("wr_cnt_ffff", 64'(pkt_cnt_o), 64'hFFFF);
      check("wr_gnt", 64'(gnt_idx_o), 64'd0);
      tick();
      settle();
      check("wr_cnt_zero", 64'(pkt_cnt_o), 64'h0000);
      valid_i = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
